rv_fetch_unit: RTL

- Instruction fetch unit: generates the PC stream, issues word reads to instruction memory, and presents in-order opcode/PC pairs to the decoder's i_opcode / i_pc inputs.
- It is the producer end of the decoder interface and the consumer of its redirect outputs (o_en_jump / o_jump_addr, or the resolved branch/JALR target from execute).
- It buffers returned words in a small FIFO, tracks in-flight requests, and discards stale responses after a redirect.

---
 rtl/rv_fetch_unit_if.sv | 67 ++++++
 rtl/rv_fetch_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rv_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// rv_fetch_unit_if
//
// Bundles every handshake/bus signal of the instruction fetch unit.
// Signal names keep the fetch unit's own point of view: o_* are driven by
// the fetch unit, i_* are driven by its surroundings (memory, decoder,
// redirect source).
//
// Valid/ready semantics (applies to both the imem request channel and the
// decoder channel): a transfer happens on a rising clock edge where valid
// and ready are both 1. A producer holding valid=1 keeps its payload stable
// until the transfer, except when a redirect flushes the channel. The
// response channel has no ready: i_imem_rsp_valid is always accepted.
//
// Groups:
//   imem request : o_imem_req_valid, i_imem_req_ready, o_imem_addr
//   imem response: i_imem_rsp_valid, i_imem_rsp_data
//   decoder      : o_valid, i_ready, o_opcode, o_pc
//   redirect     : i_redirect, i_redirect_addr
//   trap         : o_misaligned
//
// Modports: master = fetch unit, slave = environment.
// ---------------------------------------------------------------------------
interface rv_fetch_unit_if;
  logic        o_imem_req_valid;
  logic        i_imem_req_ready;
  logic [31:0] o_imem_addr;
  logic        i_imem_rsp_valid;
  logic [31:0] i_imem_rsp_data;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_opcode;
  logic [31:0] o_pc;
  logic        i_redirect;
  logic [31:0] i_redirect_addr;
  logic        o_misaligned;

  modport master (
    output o_imem_req_valid,
    input  i_imem_req_ready,
    output o_imem_addr,
    input  i_imem_rsp_valid,
    input  i_imem_rsp_data,
    output o_valid,
    input  i_ready,
    output o_opcode,
    output o_pc,
    input  i_redirect,
    input  i_redirect_addr,
    output o_misaligned
  );

  modport slave (
    input  o_imem_req_valid,
    output i_imem_req_ready,
    input  o_imem_addr,
    output i_imem_rsp_valid,
    output i_imem_rsp_data,
    input  o_valid,
    output i_ready,
    input  o_opcode,
    input  o_pc,
    output i_redirect,
    output i_redirect_addr,
    input  o_misaligned
  );
endinterface

// File: rtl/rv_fetch_unit.sv
// ---------------------------------------------------------------------------
// rv_fetch_unit
//
// Instruction fetch unit. Generates a sequential PC stream, issues word
// reads to instruction memory, buffers returned words together with their
// PCs in a small FIFO and presents them in order to the decoder. A redirect
// flushes the buffer, restarts fetch at the new PC and arranges for every
// response still in flight to be discarded when it arrives.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   bus          rv_fetch_unit_if.master (imem request/response, decoder
//                output, redirect input, misaligned trap)
//   o_dbg_state  current FSM state (0 = RUN, 1 = HALT)
//
// Optional feature, macro RV_FETCH_MISALIGN_CHECK_EN:
//   defined   - a redirect to a non word aligned address flushes and enters
//               HALT (no requests, in-flight responses dropped, sticky
//               o_misaligned=1) until an aligned redirect returns to RUN.
//   undefined - redirect address bits [1:0] are ignored, o_misaligned is 0
//               and the unit never leaves RUN.
// ---------------------------------------------------------------------------
module rv_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          CNT_W      = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  rv_fetch_unit_if.master bus,
  output logic [0:0]      o_dbg_state
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(FIFO_DEPTH);

  logic [31:0]      fetch_pc;
  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] outstanding_nxt;
  logic [CNT_W-1:0] drop;
  logic [CNT_W-1:0] fifo_cnt;

  // PCs of accepted requests, oldest first; one entry per in-flight request.
  logic [31:0]      pcq [FIFO_DEPTH];
  logic [AW-1:0]    pcq_wr;
  logic [AW-1:0]    pcq_rd;

  // Instruction buffer: word and its PC.
  logic [31:0]      fifo_data [FIFO_DEPTH];
  logic [31:0]      fifo_pc   [FIFO_DEPTH];
  logic [AW-1:0]    fifo_wr;
  logic [AW-1:0]    fifo_rd;

  logic             redirect;
  logic             req_valid;
  logic             req_hs;
  logic             rsp;
  logic             pop;
  logic             keep;
  logic             mis_redirect;
  logic [CNT_W:0]   used;
  logic [31:0]      redirect_pc;

  assign redirect    = bus.i_redirect;
  assign rsp         = bus.i_imem_rsp_valid;
  assign redirect_pc = {bus.i_redirect_addr[31:2], 2'b00};

  // An output handshake in a redirect cycle is void: the entry is flushed.
  assign pop  = (fifo_cnt != '0) & bus.i_ready & ~redirect;
  // Responses are kept only when nothing is pending for discard and no
  // redirect happens in the same cycle.
  assign keep = rsp & (drop == '0) & ~redirect;

  // Credit: in-flight requests plus buffered words must stay below the
  // buffer depth. The entry leaving this cycle already frees its slot, which
  // is what lets a 1-cycle memory sustain one instruction per cycle.
  assign used = {1'b0, outstanding} + {1'b0, fifo_cnt} - (CNT_W + 1)'(pop);

  // Gated directly by i_rst_n so no request is shown while reset is held.
  assign req_valid = i_rst_n & (state == ST_RUN) & ~redirect & (used < DEPTH_W);
  assign req_hs    = req_valid & bus.i_imem_req_ready;

  assign outstanding_nxt = outstanding + CNT_W'(req_hs) - CNT_W'(rsp);

`ifdef RV_FETCH_MISALIGN_CHECK_EN
  logic misaligned_q;

  assign mis_redirect = redirect & (bus.i_redirect_addr[1:0] != 2'b00);

  always_comb begin
    state_nxt = state;
    if (redirect) begin
      state_nxt = mis_redirect ? ST_HALT : ST_RUN;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      misaligned_q <= 1'b0;
    end else if (redirect) begin
      misaligned_q <= mis_redirect;
    end
  end

  assign bus.o_misaligned = misaligned_q;
`else
  logic unused_addr_lsb;

  assign unused_addr_lsb  = ^bus.i_redirect_addr[1:0];
  assign mis_redirect     = 1'b0;
  assign bus.o_misaligned = 1'b0;

  always_comb begin
    state_nxt = ST_RUN;
    if (mis_redirect) begin
      state_nxt = ST_HALT;
    end
  end
`endif

  // Fetch PC, FSM state and request/drop bookkeeping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_pc    <= RESET_PC;
      state       <= ST_RUN;
      outstanding <= '0;
      drop        <= '0;
      pcq_wr      <= '0;
      pcq_rd      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pcq[i] <= '0;
      end
    end else begin
      state       <= state_nxt;
      outstanding <= outstanding_nxt;

      if (redirect) begin
        fetch_pc <= redirect_pc;
      end else if (req_hs) begin
        fetch_pc <= fetch_pc + 32'd4;
      end

      // Everything still in flight after this edge belongs to the old
      // stream, including a request accepted in the redirect cycle; a
      // response arriving in the redirect cycle is already excluded.
      if (redirect) begin
        drop <= outstanding_nxt;
      end else if (rsp && (drop != '0)) begin
        drop <= drop - CNT_W'(1);
      end

      if (req_hs) begin
        pcq[pcq_wr] <= fetch_pc;
        pcq_wr      <= pcq_wr + AW'(1);
      end
      if (rsp) begin
        pcq_rd <= pcq_rd + AW'(1);
      end
    end
  end

  // Instruction buffer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fifo_cnt <= '0;
      fifo_wr  <= '0;
      fifo_rd  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else if (redirect) begin
      fifo_cnt <= '0;
      fifo_wr  <= '0;
      fifo_rd  <= '0;
    end else begin
      if (keep) begin
        fifo_data[fifo_wr] <= bus.i_imem_rsp_data;
        fifo_pc[fifo_wr]   <= pcq[pcq_rd];
        fifo_wr            <= fifo_wr + AW'(1);
      end
      if (pop) begin
        fifo_rd <= fifo_rd + AW'(1);
      end
      fifo_cnt <= fifo_cnt + CNT_W'(keep) - CNT_W'(pop);
    end
  end

  assign bus.o_imem_req_valid = req_valid;
  assign bus.o_imem_addr      = fetch_pc;
  assign bus.o_valid          = (fifo_cnt != '0);
  assign bus.o_opcode         = fifo_data[fifo_rd];
  assign bus.o_pc             = fifo_pc[fifo_rd];
  assign o_dbg_state          = state;

endmodule
